// File: rtl/seq_mult_pkg.sv
// Shared types and configuration limits for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BPC_MIN   = 1;
  localparam int BPC_MAX   = 2;
  localparam int WIDTH_MIN = 4;

  // Radix-4 stepping consumes the multiplier in pairs, so the width must split evenly.
  function automatic bit cfg_ok(input int width, input int bpc);
    return (width >= WIDTH_MIN) && (bpc >= BPC_MIN) && (bpc <= BPC_MAX) &&
           ((bpc == 1) || ((width % 2) == 0));
  endfunction

endpackage

// File: rtl/csel_add_w.sv
// Parametrised carry-select adder built from 4-bit blocks; the last block may be narrower.
module csel_add_w #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int BLK = 4;
  localparam int NB  = (W + BLK - 1) / BLK;

  // Each block precomputes both carry-in outcomes; the incoming carry only drives a mux.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int LO = i * BLK;
    localparam int HI = ((LO + BLK) > W) ? (W - 1) : (LO + BLK - 1);
    localparam int BW = HI - LO + 1;

    logic          ci;
    logic          co;
    logic [BW:0]   s0;
    logic [BW:0]   s1;

    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_blk[i-1].co;
    end

    assign s0 = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]};
    assign s1 = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]} + {{BW{1'b0}}, 1'b1};

    assign sum[HI:LO] = ci ? s1[BW-1:0] : s0[BW-1:0];
    assign co         = ci ? s1[BW] : s0[BW];
  end

  assign cout = g_blk[NB-1].co;

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed,
// retiring BPC multiplier bits per cycle on unsigned magnitudes with a final sign fix.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mlier,
  output logic               ready,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int AW    = WIDTH + BPC;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0]    STEPS_C = CW'(STEPS);
  localparam logic [CW-1:0]    ONE_C   = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  if (!cfg_ok(WIDTH, BPC)) begin : g_bad_cfg
    $error("seq_mult_param: illegal WIDTH=%0d / BPC=%0d", WIDTH, BPC);
  end

  state_t              state_q;
  state_t              state_d;
  logic                accept;

  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    m_reg;
  logic [AW-1:0]       acc_hi;
  logic [CW-1:0]       count;
  logic                neg;

  logic [WIDTH-1:0]    mcand_mag;
  logic [WIDTH-1:0]    mlier_mag;
  logic [AW-1:0]       a_ext;
  logic [AW-1:0]       pp;
  logic [AW-1:0]       sum_a;
  logic                cout_a;
  logic [AW-1:0]       acc_next;
  logic [WIDTH-1:0]    m_next;
  logic [2*WIDTH-1:0]  raw_prod;
  logic [2*WIDTH-1:0]  neg_sum;
  logic                neg_cout;
  logic [2*WIDTH-1:0]  fix_val;

  // -2^(WIDTH-1) negates onto itself, which is exactly its unsigned magnitude.
  assign mcand_mag = (tc && mcand[WIDTH-1]) ? (~mcand + ONE_W) : mcand;
  assign mlier_mag = (tc && mlier[WIDTH-1]) ? (~mlier + ONE_W) : mlier;

  assign a_ext = AW'(a_reg);

  if (BPC == 1) begin : g_pp1
    assign pp = m_reg[0] ? a_ext : '0;
  end else begin : g_pp2
    logic [WIDTH:0] a3_lo;
    logic           a3_cout;
    logic [AW-1:0]  a2;
    logic [AW-1:0]  a3;

    assign a2 = {a_reg, 1'b0};

    csel_add_w #(.W(WIDTH + 1)) u_add3 (
      .a    ({1'b0, a_reg}),
      .b    ({a_reg, 1'b0}),
      .cin  (1'b0),
      .sum  (a3_lo),
      .cout (a3_cout)
    );

    assign a3 = {a3_cout, a3_lo};

    always_comb begin
      pp = '0;
      case (m_reg[1:0])
        2'd0:    pp = '0;
        2'd1:    pp = a_ext;
        2'd2:    pp = a2;
        default: pp = a3;
      endcase
    end
  end

  csel_add_w #(.W(AW)) u_add_acc (
    .a    (acc_hi),
    .b    (pp),
    .cin  (1'b0),
    .sum  (sum_a),
    .cout (cout_a)
  );

  // The low BPC bits of the sum drop into the multiplier register as it shifts out.
  assign acc_next = AW'({cout_a, sum_a[AW-1:BPC]});
  assign m_next   = {sum_a[BPC-1:0], m_reg[WIDTH-1:BPC]};

  assign raw_prod = (2*WIDTH)'({acc_hi, m_reg});

  csel_add_w #(.W(2*WIDTH)) u_add_neg (
    .a    (raw_prod ^ {(2*WIDTH){neg}}),
    .b    ('0),
    .cin  (neg),
    .sum  (neg_sum),
    .cout (neg_cout)
  );

  assign fix_val = (2*WIDTH)'({neg_cout, neg_sum});

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN and FIX deliberately ignore start; only IDLE and DONE can take a new operation.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (count == ONE_C) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_reg   <= '0;
      m_reg   <= '0;
      acc_hi  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      valid   <= 1'b0;
      product <= '0;
    end else if (accept) begin
      a_reg   <= mcand_mag;
      m_reg   <= mlier_mag;
      acc_hi  <= '0;
      count   <= STEPS_C;
      neg     <= tc & (mcand[WIDTH-1] ^ mlier[WIDTH-1]);
      valid   <= 1'b0;
      product <= '0;
    end else if (state_q == RUN) begin
      acc_hi  <= acc_next;
      m_reg   <= m_next;
      count   <= count - ONE_C;
    end else if (state_q == FIX) begin
      product <= fix_val;
      valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param in a 16x16 radix-2 and an 8x8 radix-4 configuration.
module tb_seq_mult_param;

  logic        clock;
  logic        reset;

  logic        start16;
  logic        tc16;
  logic [15:0] mcand16;
  logic [15:0] mlier16;
  logic        ready16;
  logic        valid16;
  logic [31:0] product16;

  logic        start8;
  logic        tc8;
  logic [7:0]  mcand8;
  logic [7:0]  mlier8;
  logic        ready8;
  logic        valid8;
  logic [15:0] product8;

  int checks = 0;
  int passed = 0;

  seq_mult_param #(.WIDTH(16), .BPC(1)) dut16 (
    .clock   (clock),
    .reset   (reset),
    .start   (start16),
    .tc      (tc16),
    .mcand   (mcand16),
    .mlier   (mlier16),
    .ready   (ready16),
    .valid   (valid16),
    .product (product16)
  );

  seq_mult_param #(.WIDTH(8), .BPC(2)) dut8 (
    .clock   (clock),
    .reset   (reset),
    .start   (start8),
    .tc      (tc8),
    .mcand   (mcand8),
    .mlier   (mlier8),
    .ready   (ready8),
    .valid   (valid8),
    .product (product8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Operands are scrambled right after the accept edge to show they are no longer used.
  task automatic run16(input logic t, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat);
    @(negedge clock);
    start16 = 1'b1; tc16 = t; mcand16 = a; mlier16 = b;
    @(posedge clock); #1;
    start16 = 1'b0; tc16 = ~t; mcand16 = 16'($urandom); mlier16 = 16'($urandom);
    lat = 0;
    while (!valid16 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    p = product16;
  endtask

  task automatic run8(input logic t, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    @(negedge clock);
    start8 = 1'b1; tc8 = t; mcand8 = a; mlier8 = b;
    @(posedge clock); #1;
    start8 = 1'b0; tc8 = ~t; mcand8 = 8'($urandom); mlier8 = 8'($urandom);
    lat = 0;
    while (!valid8 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    p = product8;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (ready16 !== 1'b1) $display("[TB] FAIL reset_ready16 got %b exp 1", ready16); else passed++;
    checks++; if (valid16 !== 1'b0) $display("[TB] FAIL reset_valid16 got %b exp 0", valid16); else passed++;
    checks++; if (product16 !== 32'h0) $display("[TB] FAIL reset_product16 got %h exp 0", product16); else passed++;
    checks++; if (ready8 !== 1'b1) $display("[TB] FAIL reset_ready8 got %b exp 1", ready8); else passed++;
    checks++; if (valid8 !== 1'b0) $display("[TB] FAIL reset_valid8 got %b exp 0", valid8); else passed++;
    checks++; if (product8 !== 16'h0) $display("[TB] FAIL reset_product8 got %h exp 0", product8); else passed++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_unsigned16();
    logic [31:0] p;
    int lat;
    run16(1'b0, 16'hFFFF, 16'hFFFF, p, lat);
    checks++; if (p !== 32'hFFFE0001) $display("[TB] FAIL u16_max got %h exp fffe0001", p); else passed++;
    checks++; if (lat !== 17) $display("[TB] FAIL u16_latency got %0d exp 17", lat); else passed++;
    checks++; if (ready16 !== 1'b1) $display("[TB] FAIL u16_ready_done got %b exp 1", ready16); else passed++;
    run16(1'b0, 16'h1234, 16'h0010, p, lat);
    checks++; if (p !== 32'h00012340) $display("[TB] FAIL u16_shift got %h exp 00012340", p); else passed++;
    run16(1'b0, 16'h0000, 16'hFFFF, p, lat);
    checks++; if (p !== 32'h0) $display("[TB] FAIL u16_zero got %h exp 0", p); else passed++;
  endtask

  task automatic test_signed16();
    logic [31:0] p;
    int lat;
    run16(1'b1, 16'h8000, 16'h8000, p, lat);
    checks++; if (p !== 32'h40000000) $display("[TB] FAIL s16_minmin got %h exp 40000000", p); else passed++;
    run16(1'b1, 16'hFFFD, 16'h0005, p, lat);
    checks++; if (p !== 32'hFFFFFFF1) $display("[TB] FAIL s16_m3x5 got %h exp fffffff1", p); else passed++;
    run16(1'b1, 16'h7FFF, 16'h8000, p, lat);
    checks++; if (p !== 32'hC0008000) $display("[TB] FAIL s16_maxmin got %h exp c0008000", p); else passed++;
    run16(1'b1, 16'hFFFF, 16'hFFFF, p, lat);
    checks++; if (p !== 32'h00000001) $display("[TB] FAIL s16_m1m1 got %h exp 00000001", p); else passed++;
    run16(1'b1, 16'h0000, 16'hFFFF, p, lat);
    checks++; if (p !== 32'h0) $display("[TB] FAIL s16_negzero got %h exp 0", p); else passed++;
  endtask

  task automatic test_radix4();
    logic [15:0] p;
    int lat;
    run8(1'b0, 8'hFF, 8'hFF, p, lat);
    checks++; if (p !== 16'hFE01) $display("[TB] FAIL r4_umax got %h exp fe01", p); else passed++;
    checks++; if (lat !== 5) $display("[TB] FAIL r4_latency got %0d exp 5", lat); else passed++;
    run8(1'b1, 8'h80, 8'h7F, p, lat);
    checks++; if (p !== 16'hC080) $display("[TB] FAIL r4_minmax got %h exp c080", p); else passed++;
    run8(1'b1, 8'h80, 8'h80, p, lat);
    checks++; if (p !== 16'h4000) $display("[TB] FAIL r4_minmin got %h exp 4000", p); else passed++;
    run8(1'b0, 8'h03, 8'h07, p, lat);
    checks++; if (p !== 16'h0015) $display("[TB] FAIL r4_3x7 got %h exp 0015", p); else passed++;
    run8(1'b1, 8'hFD, 8'h05, p, lat);
    checks++; if (p !== 16'hFFF1) $display("[TB] FAIL r4_m3x5 got %h exp fff1", p); else passed++;
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clock);
    start16 = 1'b1; tc16 = 1'b0; mcand16 = 16'h0003; mlier16 = 16'h0007;
    @(posedge clock); #1;
    start16 = 1'b0;
    lat = 0;
    while (!valid16 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 3) begin
        start16 = 1'b1; tc16 = 1'b1; mcand16 = 16'hFFFF; mlier16 = 16'h8000;
      end else begin
        start16 = 1'b0;
      end
    end
    checks++; if (product16 !== 32'h00000015) $display("[TB] FAIL ignore_product got %h exp 00000015", product16); else passed++;
    checks++; if (lat !== 17) $display("[TB] FAIL ignore_latency got %0d exp 17", lat); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] p;
    int lat;
    int spurious;
    @(negedge clock);
    start16 = 1'b1; tc16 = 1'b0; mcand16 = 16'h00FF; mlier16 = 16'h00FF;
    @(posedge clock); #1;
    start16 = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    checks++; if (valid16 !== 1'b0) $display("[TB] FAIL abort_valid got %b exp 0", valid16); else passed++;
    checks++; if (product16 !== 32'h0) $display("[TB] FAIL abort_product got %h exp 0", product16); else passed++;
    checks++; if (ready16 !== 1'b1) $display("[TB] FAIL abort_ready got %b exp 1", ready16); else passed++;
    spurious = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (valid16) spurious++;
    end
    checks++; if (spurious !== 0) $display("[TB] FAIL abort_no_valid got %0d exp 0", spurious); else passed++;
    run16(1'b0, 16'h0100, 16'h0100, p, lat);
    checks++; if (p !== 32'h00010000) $display("[TB] FAIL abort_restart got %h exp 00010000", p); else passed++;
    checks++; if (lat !== 17) $display("[TB] FAIL abort_restart_lat got %0d exp 17", lat); else passed++;
  endtask

  task automatic test_back_to_back();
    int gap;
    int waited;
    @(negedge clock);
    start8 = 1'b1; tc8 = 1'b0; mcand8 = 8'h0F; mlier8 = 8'h0F;
    waited = 0;
    @(posedge clock); #1;
    while (!valid8 && waited < 100) begin
      @(posedge clock); #1;
      waited++;
    end
    checks++; if (product8 !== 16'h00E1) $display("[TB] FAIL b2b_first got %h exp 00e1", product8); else passed++;
    for (int r = 0; r < 2; r++) begin
      gap = 0;
      @(posedge clock); #1;
      while (!valid8 && gap < 100) begin
        gap++;
        @(posedge clock); #1;
      end
      checks++; if (gap !== 5) $display("[TB] FAIL b2b_gap%0d got %0d exp 5", r, gap); else passed++;
      checks++; if (product8 !== 16'h00E1) $display("[TB] FAIL b2b_product%0d got %h exp 00e1", r, product8); else passed++;
    end
    start8 = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    start16 = 1'b0; tc16 = 1'b0; mcand16 = '0; mlier16 = '0;
    start8  = 1'b0; tc8  = 1'b0; mcand8  = '0; mlier8  = '0;
    test_reset();
    test_unsigned16();
    test_signed16();
    test_radix4();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
